rx_ptp_parser: RTL and testbench

- Upstream writer for the rx timestamp buffer.
- Consumes the MAC receive byte stream and the receive timestamp captured at start-of-frame.
- Filters gPTP frames and extracts the 80-bit timestamp field carried in the message.
- Writes one record per accepted frame: one-hot type address, rx timestamp (data1) and carried timestamp (data2), each write a single-cycle valid pulse.

---
 rtl/rx_ptp_parser.sv | 149 ++++++++++++++
 tb/tb_rx_ptp_parser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ptp_parser.sv
// rx_ptp_parser: filters gPTP frames out of the MAC receive byte stream and
// writes one {one-hot type, rx timestamp, carried timestamp} record per accepted frame.
`timescale 1ns/1ps
module rx_ptp_parser #(
    parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7,
    parameter logic [3:0]  PTP_VERSION   = 4'h2,
    parameter int          DROP_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_sof,
    input  logic                  rx_eof,
    input  logic                  rx_err,
    input  logic [79:0]           rx_ts,
    input  logic                  rx_rev_wr_v_ready,
    output logic                  rx_rev_wr_vaild,
    output logic [7:0]            rx_rev_wr_addr,
    output logic [79:0]           rx_rev_wr_data1,
    output logic [79:0]           rx_rev_wr_data2,
    output logic [DROP_CNT_W-1:0] rx_drop_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, DISCARD, PEND} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [5:0]  idx;
    logic [7:0]  eth_hi;
    logic [7:0]  type_q;
    logic [7:0]  type_map;
    logic [79:0] d1_sh;
    logic [79:0] d2_sh;
    logic [79:0] d2_next;
    logic        ether_bad;
    logic        type_bad;
    logic        ver_bad;
    logic        frame_ok;
    logic        drop_evt;

    function automatic logic [7:0] map_type(input logic [3:0] t);
        case (t)
            4'h0:    map_type = 8'h01;
            4'h8:    map_type = 8'h02;
            4'h2:    map_type = 8'h04;
            4'h3:    map_type = 8'h08;
            4'hA:    map_type = 8'h10;
            4'hB:    map_type = 8'h20;
            4'hC:    map_type = 8'h40;
            4'hD:    map_type = 8'h80;
            default: map_type = 8'h00;
        endcase
    endfunction

    // idx is the byte index of the byte currently on rx_data (non-sof bytes)
    always_comb begin
        idx       = (cnt == 6'd63) ? 6'd63 : cnt + 6'd1;
        type_map  = map_type(rx_data[3:0]);
        ether_bad = (idx == 6'd13) && ({eth_hi, rx_data} != PTP_ETHERTYPE);
        type_bad  = (idx == 6'd14) && (type_map == 8'h00);
        ver_bad   = (idx == 6'd15) && (rx_data[3:0] != PTP_VERSION);
        frame_ok  = !rx_err && (idx >= 6'd57);
        d2_next   = ((idx >= 6'd48) && (idx <= 6'd57)) ? {d2_sh[71:0], rx_data} : d2_sh;
    end

    // All drop reasons seen in one cycle collapse into a single increment
    always_comb begin
        drop_evt = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE, DISCARD: drop_evt = rx_sof && rx_eof;
                RECV: begin
                    if (rx_sof)
                        drop_evt = 1'b1;
                    else if (rx_eof)
                        drop_evt = !ether_bad && !frame_ok;
                    else
                        drop_evt = type_bad || ver_bad;
                end
                PEND:    drop_evt = rx_sof;
                default: drop_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            eth_hi          <= '0;
            type_q          <= '0;
            d1_sh           <= '0;
            d2_sh           <= '0;
            rx_rev_wr_vaild <= 1'b0;
            rx_rev_wr_addr  <= '0;
            rx_rev_wr_data1 <= '0;
            rx_rev_wr_data2 <= '0;
            rx_drop_cnt     <= '0;
        end else begin
            rx_rev_wr_vaild <= 1'b0;
            if (drop_evt && (rx_drop_cnt != '1))
                rx_drop_cnt <= rx_drop_cnt + DROP_CNT_W'(1);

            // A new frame is taken from any state except PEND, where it is skipped whole
            if (rx_valid && rx_sof && (state != PEND)) begin
                state <= rx_eof ? IDLE : RECV;
                cnt   <= '0;
                d1_sh <= rx_ts;
                d2_sh <= '0;
            end else begin
                case (state)
                    RECV: begin
                        if (rx_valid) begin
                            cnt   <= idx;
                            d2_sh <= d2_next;
                            if (idx == 6'd12)
                                eth_hi <= rx_data;
                            if (idx == 6'd14)
                                type_q <= type_map;
                            if (rx_eof) begin
                                if (frame_ok) begin
                                    rx_rev_wr_addr  <= type_q;
                                    rx_rev_wr_data1 <= d1_sh;
                                    rx_rev_wr_data2 <= d2_next;
                                    state           <= PEND;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (ether_bad || type_bad || ver_bad) begin
                                state <= DISCARD;
                            end
                        end
                    end
                    DISCARD: begin
                        if (rx_valid && rx_eof)
                            state <= IDLE;
                    end
                    PEND: begin
                        if (rx_rev_wr_v_ready) begin
                            rx_rev_wr_vaild <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_ptp_parser.sv
// tb_rx_ptp_parser: table-driven frame vectors plus hand-written multi-cycle
// sequences (backpressure, busy drop, back-to-back, saturation, mid-frame reset).
`timescale 1ns/1ps
module tb_rx_ptp_parser;
    localparam int DW = 4;
    localparam int SAT = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_sof = 1'b0;
    logic          rx_eof = 1'b0;
    logic          rx_err = 1'b0;
    logic [79:0]   rx_ts = '0;
    logic          ready = 1'b1;
    logic          vaild;
    logic [7:0]    addr;
    logic [79:0]   data1;
    logic [79:0]   data2;
    logic [DW-1:0] drop_cnt;

    rx_ptp_parser #(.DROP_CNT_W(DW)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .rx_ts(rx_ts),
        .rx_rev_wr_v_ready(ready), .rx_rev_wr_vaild(vaild), .rx_rev_wr_addr(addr),
        .rx_rev_wr_data1(data1), .rx_rev_wr_data2(data2), .rx_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int eof_cyc = 0;
    int sof_cyc = 0;
    int exp_drop = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [79:0] d1;
        logic [79:0] d2;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        int          len;
        logic [15:0] eth;
        logic [7:0]  b14;
        logic [7:0]  b15;
        logic [79:0] ts2;
        logic [79:0] rxts;
        logic        err;
        logic        gaps;
        logic        wr;
        logic [7:0]  addr;
        int          drop;
    } vec_t;
    vec_t vt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (vaild) begin
            checkOutput("no_back_to_back_pulse", 80'(prev_v), 80'(0));
            wq.push_back('{addr, data1, data2, cyc});
        end
        prev_v = vaild;
    end

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_data = 8'hEE;
        end
    endtask

    // Drives bytes [first, last) of a len-byte frame, then one idle cycle
    task automatic applyStimulus(input int len, input logic [15:0] eth, input logic [7:0] b14,
                                 input logic [7:0] b15, input logic [79:0] ts2,
                                 input logic [79:0] rxts, input logic err, input logic gaps,
                                 input int first, input int last);
        logic [7:0] b;
        for (int i = first; i < last; i++) begin
            if (gaps && (i % 7 == 3)) begin
                @(posedge clk); #1;
                rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'hFF;
            end
            if (i == 12)                   b = eth[15:8];
            else if (i == 13)              b = eth[7:0];
            else if (i == 14)              b = b14;
            else if (i == 15)              b = b15;
            else if (i >= 48 && i <= 57)   b = ts2[79-8*(i-48) -: 8];
            else                           b = 8'(i * 3 + 1);
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = b;
            rx_sof   = (i == 0);
            rx_eof   = (i == len - 1);
            rx_err   = (i == len - 1) ? err : 1'b0;
            rx_ts    = (i == 0) ? rxts : ~rxts;
            if (i == 0) sof_cyc = cyc;
            if (i == len - 1) eof_cyc = cyc;
        end
        idleCycles(1);
    endtask

    task automatic checkDrop(input string name);
        checkOutput(name, 80'(drop_cnt), 80'(exp_drop));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vt.push_back('{60, 16'h88F7, 8'h00, 8'h02, 80'h123456789ABC00000002, 80'h123456789ABC00000001, 1'b0, 1'b0, 1'b1, 8'h01, 0});
        vt.push_back('{60, 16'h0800, 8'h00, 8'h02, 80'h11, 80'h21, 1'b0, 1'b0, 1'b0, 8'h00, 0});
        vt.push_back('{60, 16'h88F7, 8'h00, 8'h02, 80'h12, 80'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1});
        vt.push_back('{60, 16'h88F7, 8'h05, 8'h02, 80'h13, 80'h23, 1'b0, 1'b0, 1'b0, 8'h00, 1});
        vt.push_back('{41, 16'h88F7, 8'h00, 8'h02, 80'h14, 80'h24, 1'b0, 1'b0, 1'b0, 8'h00, 1});
        vt.push_back('{60, 16'h88F7, 8'h08, 8'h03, 80'h15, 80'h25, 1'b0, 1'b0, 1'b0, 8'h00, 1});
        vt.push_back('{58, 16'h88F7, 8'h0D, 8'h02, 80'hA1A2A3A4A5A6A7A8A9AA, 80'h31, 1'b0, 1'b0, 1'b1, 8'h80, 0});
        vt.push_back('{57, 16'h88F7, 8'h0D, 8'h02, 80'h16, 80'h26, 1'b0, 1'b0, 1'b0, 8'h00, 1});
        vt.push_back('{64, 16'h88F7, 8'h1C, 8'h12, 80'hCAFE0000BEEF00001234, 80'h32, 1'b0, 1'b1, 1'b1, 8'h40, 0});
        vt.push_back('{70, 16'h88F7, 8'h0B, 8'h02, 80'h0102030405060708090A, 80'h33, 1'b0, 1'b1, 1'b1, 8'h20, 0});
        vt.push_back('{60, 16'h88F7, 8'h02, 8'h02, 80'hFFEEDDCCBBAA99887766, 80'h34, 1'b0, 1'b0, 1'b1, 8'h04, 0});
        vt.push_back('{60, 16'h88F7, 8'h0A, 8'h02, 80'h00000000000000000001, 80'h35, 1'b0, 1'b0, 1'b1, 8'h10, 0});
        vt.push_back('{60, 16'h88F7, 8'h08, 8'h02, 80'h8000000000000000000F, 80'h36, 1'b0, 1'b0, 1'b1, 8'h02, 0});
        vt.push_back('{60, 16'h88F7, 8'h03, 8'h02, 80'h5555AAAA5555AAAA5555, 80'h37, 1'b0, 1'b0, 1'b1, 8'h08, 0});
        vt.push_back('{60, 16'h88F6, 8'h00, 8'h02, 80'h17, 80'h27, 1'b0, 1'b0, 1'b0, 8'h00, 0});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_vaild", 80'(vaild), 80'(0));
        checkOutput("reset_addr", 80'(addr), 80'(0));
        checkOutput("reset_data1", data1, 80'(0));
        checkOutput("reset_data2", data2, 80'(0));
        checkDrop("reset_drop");
        reset = 1'b1;
        idleCycles(2);

        // Table-driven frames, v_ready held high
        for (int i = 0; i < vt.size(); i++) begin
            wq.delete();
            applyStimulus(vt[i].len, vt[i].eth, vt[i].b14, vt[i].b15, vt[i].ts2, vt[i].rxts,
                          vt[i].err, vt[i].gaps, 0, vt[i].len);
            idleCycles(4);
            exp_drop = sat(exp_drop + vt[i].drop);
            checkOutput($sformatf("v%0d_writes", i), 80'(wq.size()), 80'(vt[i].wr ? 1 : 0));
            if (vt[i].wr && wq.size() > 0) begin
                checkOutput($sformatf("v%0d_addr", i), 80'(wq[0].addr), 80'(vt[i].addr));
                checkOutput($sformatf("v%0d_data1", i), wq[0].d1, vt[i].rxts);
                checkOutput($sformatf("v%0d_data2", i), wq[0].d2, vt[i].ts2);
                checkOutput($sformatf("v%0d_latency", i), 80'(wq[0].cyc - eof_cyc), 80'(2));
            end
            checkDrop($sformatf("v%0d_drop", i));
        end
        checkOutput("hold_addr_after_reject", 80'(addr), 80'(8'h08));

        // Pdelay_Resp with v_ready low for 5 cycles after eof
        wq.delete();
        ready = 1'b0;
        applyStimulus(60, 16'h88F7, 8'h13, 8'h02, 80'h0BADF00D, 80'h77, 1'b0, 1'b0, 0, 60);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_nopulse%0d", k), 80'(wq.size()), 80'(0));
            checkOutput($sformatf("bp_addr%0d", k), 80'(addr), 80'(8'h08));
            checkOutput($sformatf("bp_data2_%0d", k), data2, 80'h0BADF00D);
            idleCycles(1);
        end
        ready = 1'b1;
        begin
            int rc;
            rc = cyc;
            idleCycles(4);
            checkOutput("bp_writes", 80'(wq.size()), 80'(1));
            if (wq.size() > 0) begin
                checkOutput("bp_pulse_cycle", 80'(wq[0].cyc - rc), 80'(1));
                checkOutput("bp_pulse_addr", 80'(wq[0].addr), 80'(8'h08));
                checkOutput("bp_pulse_data1", wq[0].d1, 80'h77);
            end
        end
        checkDrop("bp_drop");

        // Busy drop: second frame arrives while first is PEND; PEND ends mid-frame
        wq.delete();
        ready = 1'b0;
        applyStimulus(60, 16'h88F7, 8'h00, 8'h02, 80'hAAAA, 80'h41, 1'b0, 1'b0, 0, 60);
        fork
            applyStimulus(60, 16'h88F7, 8'h08, 8'h02, 80'hBBBB, 80'h42, 1'b0, 1'b0, 0, 60);
            begin
                repeat (20) @(posedge clk);
                #1 ready = 1'b1;
            end
        join
        idleCycles(4);
        exp_drop = sat(exp_drop + 1);
        checkOutput("busy_writes", 80'(wq.size()), 80'(1));
        if (wq.size() > 0) begin
            checkOutput("busy_addr", 80'(wq[0].addr), 80'(8'h01));
            checkOutput("busy_data2", wq[0].d2, 80'hAAAA);
        end
        checkDrop("busy_drop");

        // Back-to-back Follow_Up, second sof lands in the pulse cycle
        wq.delete();
        applyStimulus(60, 16'h88F7, 8'h08, 8'h02, 80'h1111, 80'h51, 1'b0, 1'b0, 0, 60);
        applyStimulus(60, 16'h88F7, 8'h08, 8'h02, 80'h2222, 80'h52, 1'b0, 1'b0, 0, 60);
        idleCycles(4);
        checkOutput("b2b_writes", 80'(wq.size()), 80'(2));
        if (wq.size() == 2) begin
            checkOutput("b2b_sof_in_pulse", 80'(wq[0].cyc), 80'(sof_cyc));
            checkOutput("b2b_addr0", 80'(wq[0].addr), 80'(8'h02));
            checkOutput("b2b_data2_0", wq[0].d2, 80'h1111);
            checkOutput("b2b_addr1", 80'(wq[1].addr), 80'(8'h02));
            checkOutput("b2b_data2_1", wq[1].d2, 80'h2222);
            checkOutput("b2b_data1_1", wq[1].d1, 80'h52);
        end
        checkDrop("b2b_drop");

        // Drop counter saturation
        for (int k = 0; k < 12; k++) begin
            applyStimulus(20, 16'h88F7, 8'h00, 8'h02, 80'h0, 80'h0, 1'b0, 1'b0, 0, 20);
            exp_drop = sat(exp_drop + 1);
        end
        idleCycles(2);
        checkDrop("sat_drop");
        checkOutput("sat_at_ones", 80'(drop_cnt), 80'(SAT));

        // Reset mid-frame, then a good Announce frame
        wq.delete();
        applyStimulus(60, 16'h88F7, 8'h00, 8'h02, 80'h9999, 80'h61, 1'b0, 1'b0, 0, 30);
        reset = 1'b0;
        #1;
        exp_drop = 0;
        checkOutput("mid_reset_addr", 80'(addr), 80'(0));
        checkOutput("mid_reset_data1", data1, 80'(0));
        checkOutput("mid_reset_data2", data2, 80'(0));
        checkDrop("mid_reset_drop");
        idleCycles(3);
        reset = 1'b1;
        applyStimulus(60, 16'h88F7, 8'h00, 8'h02, 80'h9999, 80'h61, 1'b0, 1'b0, 30, 60);
        idleCycles(4);
        checkOutput("mid_reset_no_write", 80'(wq.size()), 80'(0));
        applyStimulus(60, 16'h88F7, 8'h0B, 8'h02, 80'h7777, 80'h62, 1'b0, 1'b0, 0, 60);
        idleCycles(4);
        checkOutput("post_reset_writes", 80'(wq.size()), 80'(1));
        if (wq.size() > 0) begin
            checkOutput("post_reset_addr", 80'(wq[0].addr), 80'(8'h20));
            checkOutput("post_reset_data2", wq[0].d2, 80'h7777);
        end
        checkDrop("post_reset_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
